// File: rtl/sm83_flags_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm83_flags_seq : micro-sequencer for SM83 flags-unit control strobes       |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module sm83_flags_seq (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       sub,
  input  logic       step_en,
  input  logic       flush,
  output logic       ready,
  output logic       done,
  output logic       illegal,
  output logic       flags_bus,
  output logic       flags_alu,
  output logic       zero_we,
  output logic       zero_loop,
  output logic       half_carry_we,
  output logic       half_carry_cpl,
  output logic       daa_carry_we,
  output logic       neg_we,
  output logic       neg_set,
  output logic       neg_clr,
  output logic       carry_we,
  output logic       sec_carry_we,
  output logic       sec_carry_sh,
  output logic       sec_carry_daa,
  output logic       sec_carry_sel,
  output logic       carry_cpl
);

  localparam logic [2:0] OP_ALU8   = 3'd0;
  localparam logic [2:0] OP_ADD16  = 3'd1;
  localparam logic [2:0] OP_ZERO16 = 3'd2;
  localparam logic [2:0] OP_LOADF  = 3'd3;
  localparam logic [2:0] OP_DAA    = 3'd4;
  localparam logic [2:0] OP_SHIFT  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic       sub_q;

  logic active;
  logic two_step;
  logic op_illegal;
  logic last_step;

  assign active     = step_en && !flush;
  assign two_step   = (op_q == OP_ADD16) || (op_q == OP_ZERO16) || (op_q == OP_DAA);
  assign op_illegal = op_q[2] && op_q[1];
  assign last_step  = ((state == STEP1) && !two_step) || (state == STEP2);

  assign ready   = (state == IDLE) && !flush;
  assign done    = active && last_step;
  assign illegal = done && (state == STEP1) && op_illegal;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      sub_q     <= 1'b0;
      carry_cpl <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            sub_q <= sub;
            state <= STEP1;
            // carry_cpl is a sticky mode bit owned by ALU8 only
            if (op == OP_ALU8) carry_cpl <= sub;
          end
        end
        STEP1: begin
          if (step_en) state <= two_step ? STEP2 : IDLE;
        end
        STEP2: begin
          if (step_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    flags_bus      = 1'b0;
    flags_alu      = 1'b0;
    zero_we        = 1'b0;
    zero_loop      = 1'b0;
    half_carry_we  = 1'b0;
    half_carry_cpl = 1'b0;
    daa_carry_we   = 1'b0;
    neg_we         = 1'b0;
    neg_set        = 1'b0;
    neg_clr        = 1'b0;
    carry_we       = 1'b0;
    sec_carry_we   = 1'b0;
    sec_carry_sh   = 1'b0;
    sec_carry_daa  = 1'b0;
    sec_carry_sel  = 1'b0;
    if (active && (state == STEP1)) begin
      case (op_q)
        OP_ALU8: begin
          flags_alu      = 1'b1;
          zero_we        = 1'b1;
          half_carry_we  = 1'b1;
          carry_we       = 1'b1;
          neg_we         = 1'b1;
          neg_set        = sub_q;
          neg_clr        = !sub_q;
          half_carry_cpl = sub_q;
        end
        OP_ADD16: begin
          flags_alu    = 1'b1;
          sec_carry_we = 1'b1;
        end
        OP_ZERO16: begin
          flags_alu = 1'b1;
          zero_we   = 1'b1;
        end
        OP_LOADF: begin
          flags_bus     = 1'b1;
          zero_we       = 1'b1;
          neg_we        = 1'b1;
          half_carry_we = 1'b1;
          daa_carry_we  = 1'b1;
          carry_we      = 1'b1;
        end
        OP_DAA: begin
          flags_alu     = 1'b1;
          sec_carry_we  = 1'b1;
          sec_carry_daa = 1'b1;
        end
        OP_SHIFT: begin
          flags_alu     = 1'b1;
          zero_we       = 1'b1;
          half_carry_we = 1'b1;
          neg_we        = 1'b1;
          neg_clr       = 1'b1;
          sec_carry_we  = 1'b1;
          sec_carry_sh  = 1'b1;
        end
        default: ;
      endcase
    end else if (active && (state == STEP2)) begin
      case (op_q)
        OP_ADD16: begin
          flags_alu     = 1'b1;
          sec_carry_sel = 1'b1;
          half_carry_we = 1'b1;
          carry_we      = 1'b1;
          neg_we        = 1'b1;
          neg_clr       = 1'b1;
        end
        OP_ZERO16: begin
          flags_alu = 1'b1;
          zero_we   = 1'b1;
          zero_loop = 1'b1;
        end
        OP_DAA: begin
          flags_alu     = 1'b1;
          zero_we       = 1'b1;
          half_carry_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm83_flags_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sm83_flags_seq : cycle-by-cycle vector bench for sm83_flags_seq         |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sm83_flags_seq;

  logic       clk = 1'b0;
  logic       nreset;
  logic       start;
  logic [2:0] op;
  logic       sub;
  logic       step_en;
  logic       flush;
  logic ready, done, illegal, flags_bus, flags_alu, zero_we, zero_loop;
  logic half_carry_we, half_carry_cpl, daa_carry_we, neg_we, neg_set, neg_clr;
  logic carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_cpl;

  always #5 clk = ~clk;

  sm83_flags_seq dut (
    .clk(clk), .nreset(nreset), .start(start), .op(op), .sub(sub),
    .step_en(step_en), .flush(flush), .ready(ready), .done(done),
    .illegal(illegal), .flags_bus(flags_bus), .flags_alu(flags_alu),
    .zero_we(zero_we), .zero_loop(zero_loop), .half_carry_we(half_carry_we),
    .half_carry_cpl(half_carry_cpl), .daa_carry_we(daa_carry_we),
    .neg_we(neg_we), .neg_set(neg_set), .neg_clr(neg_clr), .carry_we(carry_we),
    .sec_carry_we(sec_carry_we), .sec_carry_sh(sec_carry_sh),
    .sec_carry_daa(sec_carry_daa), .sec_carry_sel(sec_carry_sel),
    .carry_cpl(carry_cpl)
  );

  logic [18:0] outs;
  assign outs = {ready, done, illegal, carry_cpl, flags_bus, flags_alu, zero_we,
                 zero_loop, half_carry_we, half_carry_cpl, daa_carry_we, neg_we,
                 neg_set, neg_clr, carry_we, sec_carry_we, sec_carry_sh,
                 sec_carry_daa, sec_carry_sel};

  localparam logic [18:0] R  = 19'd1 << 18;
  localparam logic [18:0] D  = 19'd1 << 17;
  localparam logic [18:0] I  = 19'd1 << 16;
  localparam logic [18:0] CC = 19'd1 << 15;
  localparam logic [18:0] FB = 19'd1 << 14;
  localparam logic [18:0] FA = 19'd1 << 13;
  localparam logic [18:0] ZW = 19'd1 << 12;
  localparam logic [18:0] ZL = 19'd1 << 11;
  localparam logic [18:0] HW = 19'd1 << 10;
  localparam logic [18:0] HC = 19'd1 << 9;
  localparam logic [18:0] DW = 19'd1 << 8;
  localparam logic [18:0] NW = 19'd1 << 7;
  localparam logic [18:0] NS = 19'd1 << 6;
  localparam logic [18:0] NC = 19'd1 << 5;
  localparam logic [18:0] CW = 19'd1 << 4;
  localparam logic [18:0] SW = 19'd1 << 3;
  localparam logic [18:0] SS = 19'd1 << 2;
  localparam logic [18:0] SD = 19'd1 << 1;
  localparam logic [18:0] SL = 19'd1 << 0;

  localparam logic [18:0] ALU_SUB = FA | ZW | HW | CW | NW | NS | HC;
  localparam logic [18:0] ALU_ADD = FA | ZW | HW | CW | NW | NC;
  localparam logic [18:0] ADD_S1  = FA | SW;
  localparam logic [18:0] ADD_S2  = FA | SL | HW | CW | NW | NC;
  localparam logic [18:0] Z16_S1  = FA | ZW;
  localparam logic [18:0] Z16_S2  = FA | ZW | ZL;
  localparam logic [18:0] LOADF   = FB | ZW | NW | HW | DW | CW;
  localparam logic [18:0] DAA_S1  = FA | SW | SD;
  localparam logic [18:0] SHIFT   = FA | ZW | HW | NW | NC | SW | SS;

  typedef struct {
    logic        st;
    logic [2:0]  o;
    logic        sb;
    logic        en;
    logic        fl;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic s, input logic [2:0] o, input logic sb,
                     input logic en, input logic fl, input logic [18:0] e);
    vec_t v;
    v.st = s; v.o = o; v.sb = sb; v.en = en; v.fl = fl; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [18:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b", name, idx, outs, exp);
    end
  endtask

  initial begin
    // One row per cycle: inputs held for the cycle, outputs expected in it.
    add(1, 3'd0, 1, 1, 0, R);                 // accept ALU8 sub
    add(0, 3'd0, 0, 1, 0, ALU_SUB | D | CC);
    add(1, 3'd1, 0, 1, 0, R | CC);            // accept ADD16
    add(0, 3'd0, 0, 1, 0, ADD_S1 | CC);
    add(0, 3'd0, 0, 0, 0, CC);                // stall in STEP2
    add(0, 3'd0, 0, 1, 0, ADD_S2 | D | CC);
    add(1, 3'd2, 0, 1, 0, R | CC);            // ZERO16, carry_cpl untouched
    add(0, 3'd0, 0, 1, 0, Z16_S1 | CC);
    add(0, 3'd0, 0, 1, 0, Z16_S2 | D | CC);
    add(1, 3'd3, 0, 1, 0, R | CC);            // LOADF
    add(0, 3'd0, 0, 1, 0, LOADF | D | CC);
    add(1, 3'd5, 0, 0, 0, R | CC);            // SHIFT accepted with step_en low
    add(0, 3'd0, 0, 0, 0, CC);
    add(1, 3'd0, 0, 1, 0, SHIFT | D | CC);    // start while busy: ignored
    add(0, 3'd0, 0, 1, 0, R | CC);
    add(1, 3'd0, 0, 1, 0, R | CC);            // ALU8 add clears carry_cpl
    add(0, 3'd0, 0, 1, 0, ALU_ADD | D);
    add(1, 3'd4, 0, 1, 0, R);                 // DAA, flushed in STEP2
    add(0, 3'd0, 0, 1, 0, DAA_S1);
    add(0, 3'd0, 0, 1, 1, '0);
    add(1, 3'd6, 0, 1, 0, R);                 // illegal op 6
    add(0, 3'd0, 0, 1, 0, D | I);
    add(1, 3'd7, 0, 1, 1, '0);                // flush blocks accept
    add(0, 3'd0, 0, 1, 0, R);
    add(1, 3'd7, 0, 1, 0, R);                 // illegal op 7, stalled once
    add(0, 3'd0, 0, 0, 0, '0);
    add(0, 3'd0, 0, 1, 0, D | I);
    add(0, 3'd0, 0, 1, 0, R);
    add(1, 3'd0, 1, 1, 0, R);                 // ALU8 sub flushed in STEP1
    add(0, 3'd0, 0, 1, 1, CC);
    add(0, 3'd0, 0, 1, 0, R | CC);
    add(1, 3'd1, 0, 1, 0, R | CC);            // ADD16, flushed in STEP1
    add(0, 3'd0, 0, 1, 1, CC);
    add(0, 3'd0, 0, 1, 0, R | CC);

    // Reset held with start/step_en asserted.
    nreset = 1'b0; start = 1'b1; op = 3'd3; sub = 1'b0; step_en = 1'b1; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("reset", k, R);
    end
    nreset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("first_accept", 0, LOADF | D);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; op = vecs[i].o; sub = vecs[i].sb;
      step_en = vecs[i].en; flush = vecs[i].fl;
      @(negedge clk);
      check("vec", i, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of ADD16 STEP1.
    start = 1'b1; op = 3'd1; sub = 1'b0; step_en = 1'b1; flush = 1'b0;
    @(negedge clk);
    check("mid_accept", 0, R | CC);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("mid_step1", 0, ADD_S1 | CC);
    #1 nreset = 1'b0;
    #1 check("mid_reset", 0, R);
    @(posedge clk); #1;
    check("mid_reset_hold", 0, R);
    nreset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset", k, R);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
